// File: rtl/mod_product_pkg.sv
// Shared types and helpers for the modular product engine.
package mod_product_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_MUL   = 1'b0;
  localparam logic MODE_SCALE = 1'b1;

  // Counter must reach WIDTH; one extra slot keeps the terminal value representable.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/mod_product_param_if.sv
// Request/response bundle for mod_product_param: operands, start, busy/done, result.
interface mod_product_param_if #(parameter int WIDTH = 256);
  logic             i_start;
  logic             i_mode;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic [WIDTH-1:0] i_n;
  logic [WIDTH-1:0] o_result;
  logic             o_busy;
  logic             o_done;

  modport master (
    output i_start, i_mode, i_a, i_b, i_n,
    input  o_result, o_busy, o_done
  );

  modport slave (
    input  i_start, i_mode, i_a, i_b, i_n,
    output o_result, o_busy, o_done
  );
endinterface

// File: rtl/mod_add.sv
// Combinational (x + y) mod n for x, y < n; a single conditional subtraction.
module mod_add #(
  parameter int WIDTH = 256
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] n,
  output logic [WIDTH-1:0] s
);

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] diff;

  assign sum  = {1'b0, x} + {1'b0, y};
  // When sum >= n the true difference is below n, so the low WIDTH bits are exact.
  assign diff = sum[WIDTH-1:0] - n;
  assign s    = (sum >= {1'b0, n}) ? diff : sum[WIDTH-1:0];

endmodule

// File: rtl/mod_product_param.sv
// LSB-first shift-and-add modular product: (a*b) mod N or (a*2^WIDTH) mod N.
// Optional MODPROD_EARLY_EXIT_EN stops once no multiplier bits remain.
//
// state | meaning
// IDLE  | waiting for i_start
// RUN   | one multiplier bit per cycle, cnt = 0..WIDTH
// DONE  | o_done pulse; a new start here goes straight back to RUN
module mod_product_param
  import mod_product_pkg::*;
#(
  parameter int WIDTH = 256
) (
  input logic                clk,
  input logic                rst,
  mod_product_param_if.slave bus
);

  localparam int CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] n_q;
  logic [WIDTH-1:0] t_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH:0]   e_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH-1:0] m_acc;
  logic [WIDTH-1:0] t_dbl;
  logic [WIDTH-1:0] m_next;
  logic             last;

  mod_add #(.WIDTH(WIDTH)) u_acc (.x(m_q), .y(t_q), .n(n_q), .s(m_acc));
  mod_add #(.WIDTH(WIDTH)) u_dbl (.x(t_q), .y(t_q), .n(n_q), .s(t_dbl));

  // e_q shifts right each iteration, so e_q[0] is always bit cnt of the original multiplier.
  assign m_next = e_q[0] ? m_acc : m_q;

`ifdef MODPROD_EARLY_EXIT_EN
  assign last = (cnt_q == CW'(WIDTH)) || (e_q[WIDTH:1] == '0);
`else
  assign last = (cnt_q == CW'(WIDTH));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      n_q          <= '0;
      t_q          <= '0;
      m_q          <= '0;
      e_q          <= '0;
      cnt_q        <= '0;
      bus.o_result <= '0;
      bus.o_busy   <= 1'b0;
      bus.o_done   <= 1'b0;
    end else begin
      bus.o_done <= 1'b0;
      case (state)
        RUN: begin
          m_q   <= m_next;
          t_q   <= t_dbl;
          e_q   <= e_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          if (last) begin
            state        <= DONE;
            bus.o_result <= m_next;
            bus.o_busy   <= 1'b0;
            bus.o_done   <= 1'b1;
          end
        end
        default: begin
          if (bus.i_start) begin
            state      <= RUN;
            bus.o_busy <= 1'b1;
            n_q        <= bus.i_n;
            t_q        <= bus.i_a;
            m_q        <= '0;
            cnt_q      <= '0;
            e_q        <= (bus.i_mode == MODE_SCALE) ? {1'b1, {WIDTH{1'b0}}}
                                                     : {1'b0, bus.i_b};
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_product_param.sv
// Randomized and directed bench for mod_product_param at WIDTH=8 and WIDTH=256.
module tb_mod_product_param;

  logic clk;
  logic rst;

  mod_product_param_if #(.WIDTH(8))   bus8 ();
  mod_product_param_if #(.WIDTH(256)) bus256 ();

  mod_product_param #(.WIDTH(8))   dut8   (.clk(clk), .rst(rst), .bus(bus8));
  mod_product_param #(.WIDTH(256)) dut256 (.clk(clk), .rst(rst), .bus(bus256));

  logic         st8, st256, mode;
  logic [255:0] a, b, n;
  bit           use256;

  assign bus8.i_start   = st8;
  assign bus8.i_mode    = mode;
  assign bus8.i_a       = a[7:0];
  assign bus8.i_b       = b[7:0];
  assign bus8.i_n       = n[7:0];
  assign bus256.i_start = st256;
  assign bus256.i_mode  = mode;
  assign bus256.i_a     = a;
  assign bus256.i_b     = b;
  assign bus256.i_n     = n;

  logic [255:0] cur_res;
  logic         cur_busy, cur_done;

  always_comb begin
    cur_res  = use256 ? bus256.o_result : {248'b0, bus8.o_result};
    cur_busy = use256 ? bus256.o_busy : bus8.o_busy;
    cur_done = use256 ? bus256.o_done : bus8.o_done;
  end

  int total = 0;
  int bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] ref_mod(input bit md, input logic [255:0] aa,
                                           input logic [255:0] bb, input logic [255:0] nn,
                                           input int w);
    logic [511:0] p;
    logic [511:0] r;
    if (md) p = {256'b0, aa} << w;
    else    p = {256'b0, aa} * {256'b0, bb};
    r = p % {256'b0, nn};
    return r[255:0];
  endfunction

  function automatic int ref_lat(input bit w256, input bit md, input logic [255:0] bb);
    int w;
    int hb;
    int early;
    w  = w256 ? 256 : 8;
    hb = 0;
    for (int i = 0; i < w; i++) if (bb[i]) hb = i;
`ifdef MODPROD_EARLY_EXIT_EN
    early = 1;
`else
    early = 0;
`endif
    return (early != 0 && !md) ? hb + 1 : w + 1;
  endfunction

  // Called mid-cycle; returns mid-cycle in the DONE cycle so a follow-up call is back-to-back.
  task automatic run_op(input bit w256, input bit md, input logic [255:0] aa,
                        input logic [255:0] bb, input logic [255:0] nn,
                        input int glitch_at, input string tag);
    int k, busy_cnt, lat, budget;
    logic [255:0] exp;
    use256 = w256;
    mode   = md;
    a      = aa;
    b      = bb;
    n      = nn;
    exp    = ref_mod(md, aa, bb, nn, w256 ? 256 : 8);
    lat    = ref_lat(w256, md, bb);
    budget = lat + 20;
    if (w256) st256 = 1'b1; else st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0; st256 = 1'b0;
    k = 0;
    busy_cnt = 0;
    while (!cur_done && k <= budget) begin
      if (cur_busy) busy_cnt++;
      @(posedge clk); #1;
      k++;
      st8 = 1'b0; st256 = 1'b0;
      if (k == glitch_at && k < lat) begin
        a = ~a; b = ~b; mode = ~mode;
        if (w256) st256 = 1'b1; else st8 = 1'b1;
      end
    end
    st8 = 1'b0; st256 = 1'b0;
    check_val({tag, "_lat"}, 256'(k), 256'(lat));
    check_val({tag, "_res"}, cur_res, exp);
    check_val({tag, "_busycyc"}, 256'(busy_cnt), 256'(lat));
    check_val({tag, "_busy_at_done"}, {255'b0, cur_busy}, 256'd0);
  endtask

  initial begin
    logic [255:0] n256;
    logic [255:0] ra, rb, rn;
    bit           rm;
    int           saw;

    rst = 1'b0; st8 = 1'b0; st256 = 1'b0; mode = 1'b0;
    a = '0; b = '0; n = '0; use256 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_result8", {248'b0, bus8.o_result}, 256'd0);
    check_val("rst_busy8", {255'b0, bus8.o_busy}, 256'd0);
    check_val("rst_done8", {255'b0, bus8.o_done}, 256'd0);
    check_val("rst_result256", bus256.o_result, 256'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    run_op(0, 0, 256'd7,   256'd9,   256'd13,  -1, "mul_7x9");
    run_op(0, 1, 256'd5,   256'd0,   256'd13,  -1, "scale_5");
    run_op(0, 0, 256'd250, 256'd255, 256'd251, -1, "mul_eq");
    run_op(0, 0, 256'd1,   256'd1,   256'd2,   -1, "mul_1x1");
    run_op(0, 0, 256'd7,   256'd1,   256'd13,  -1, "b_one");
    run_op(0, 0, 256'd7,   256'd0,   256'd13,  -1, "b_zero");
    run_op(0, 0, 256'd7,   256'd9,   256'd13,   2, "glitch");

    // Abort during iteration 4 (cycle after edge E4)
    use256 = 1'b0; mode = 1'b0; a = 256'd7; b = 256'd9; n = 256'd13;
    st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check_val("abort_result", {248'b0, bus8.o_result}, 256'd0);
    check_val("abort_busy", {255'b0, bus8.o_busy}, 256'd0);
    check_val("abort_done", {255'b0, bus8.o_done}, 256'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    saw = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus8.o_done || bus8.o_busy) saw++;
    end
    check_val("abort_quiet", 256'(saw), 256'd0);
    run_op(0, 0, 256'd7, 256'd9, 256'd13, -1, "post_rst");

    repeat (2) @(posedge clk);
    #1;
    n256 = (256'd1 << 255) + 256'd1;
    run_op(1, 1, 256'd1, 256'd0, n256, -1, "w256_scale");
    run_op(1, 0, 256'd3, 256'd5, n256, -1, "w256_b2b");

    for (int i = 0; i < 16; i++) begin
      rn = 256'($urandom_range(255, 2));
      ra = 256'($urandom) % rn;
      rb = 256'($urandom_range(255, 0));
      rm = 1'($urandom_range(1, 0));
      run_op(0, rm, ra, rb, rn, -1, "rand");
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mod_product_param.md
# mod_product_param

Parametrised modular product engine: computes `(a * b) mod N` or `(a * 2^WIDTH) mod N` by LSB-first shift-and-add over a configurable operand width, with a start/busy/done handshake. It is the generalised successor of the fixed 256-bit Montgomery precompute stage. It sits beside the RSA core: it supplies the 2^WIDTH-scaled operand in mode 1, and serves as a general modular multiplier in mode 0.

## Interface
- `WIDTH`, default 256: operand / modulus width in bits.
- `clk`  in  1: clock; rising edge.
- `rst`  in  1: reset; asynchronous, active-low.
- `i_start`  in  1: request pulse; sampled only in IDLE or DONE.
- `i_mode`  in  1: 0 = a*b mod N; 1 = a*2^WIDTH mod N (`i_b` ignored).
- `i_a`  in  WIDTH: multiplicand; precondition a < N.
- `i_b`  in  WIDTH: multiplier (mode 0).
- `i_n`  in  WIDTH: modulus; precondition N >= 2.
- `o_result`  out  WIDTH: result; held until the next accepted start.
- `o_busy`  out  1: high in RUN.
- `o_done`  out  1: one-cycle pulse in DONE.

## Operation
- Reset values: state IDLE, `o_result` 0, `o_busy` 0, `o_done` 0; counter, `t` and `m` cleared.
- Reset mid-operation aborts the computation immediately. No done pulse is issued.
- States and transitions:
  - IDLE, i_start=1 -> RUN.
  - RUN, last iteration -> DONE.
  - DONE, i_start=1 -> RUN (back-to-back accepted).
  - DONE, otherwise -> IDLE.
- Start accept latches `i_a`, `i_n`, `i_mode`, and an extended multiplier `e` of WIDTH+1 bits:
  - mode 0: e = {0, i_b}.
  - mode 1: e = 1 << WIDTH.
- Start accept also sets t = a, m = 0, cnt = 0.
- Each RUN cycle, with i = cnt:
  - if e[i]: m <= (m + t) mod N.
  - t <= (t + t) mod N.
  - cnt <= cnt + 1.
- Modular add: form the sum at WIDTH+1 bits. Subtract N when sum >= N (not >). One subtraction suffices because operands are < N.
- The last iteration is cnt == WIDTH. On it, o_result <= the updated m.
- `i_start` in RUN is ignored, with no queueing. Input changes after accept have no effect.
- Precondition violations (a >= N, N < 2) give an undefined result, but latency and handshake are unchanged.

## Timing
- Edge E0 accepts start. Iterations run on edges E1..E(WIDTH+1).
- `o_busy` is high from after E0 through E(WIDTH+1).
- `o_done` is high for the single cycle after E(WIDTH+1). `o_result` is valid from that cycle on.
- Fixed latency: done is visible WIDTH+1 cycles after the accept edge, in both modes.
- Back-to-back: start sampled during DONE makes the next cycle RUN, so there are no idle bubbles.
- Counter width: $clog2(WIDTH+2).

## Configuration
- `MODPROD_EARLY_EXIT_EN` defined:
  - RUN ends after iteration i when e >> (i+1) == 0. The minimum is one iteration.
  - Latency becomes (index of highest set bit of e) + 1. For b = 0 that is 1 cycle.
  - Mode 1 is always full length.
- Not defined: fixed WIDTH+1 iterations. No early-exit comparator is synthesised.

## Structure
- Package `mod_product_pkg`:
  - state enum (IDLE, RUN, DONE).
  - mode constants (MODE_MUL = 0, MODE_SCALE = 1).
  - counter-width localparam function.
- Sub-module `mod_add` (parameter WIDTH): combinational (x + y) mod N for x, y < N. It is instantiated twice, once for the accumulate and once for the doubling.

## Test plan
- WIDTH=8, mode 0, a=7, b=9, N=13 -> o_result=11; done exactly 9 cycles after accept; busy high 9 cycles.
- WIDTH=8, mode 1, a=5, N=13 -> o_result=6 (1280 mod 13).
- WIDTH=8, mode 0, a=250, b=255, N=251 -> 247. This exercises the sum >= N path including equality. Also a=1, b=1, N=2 -> 1.
- WIDTH=256, mode 1, a=1, N=2^255+1 -> 2^256 mod N = 2^255-1 = N-2. Then a back-to-back start during DONE runs mode 0 with a=3, b=5 -> 15. There must be no idle gap.
- Robustness, WIDTH=8: start pulse in mid-RUN is ignored and the result is unchanged. `rst` low at iteration 4 -> all outputs 0, IDLE, no done; a new start afterwards yields the correct result.
- `MODPROD_EARLY_EXIT_EN`, WIDTH=8, mode 0:
  - b=1 -> done 1 cycle after accept, result a mod N.
  - b=0 -> result 0 after 1 cycle.
  - mode 1 -> still 9 cycles.
